rcv_ctrl: RTL and testbench

UART receive controller that sequences the 9-bit receive shift register (`sr_9bit`). It synchronizes the raw serial line and detects the start bit. It issues one `shift_strobe` at the middle of each data bit and the stop bit, checks the captured stop bit, and hands off complete frames to the receive buffer with a ready/read handshake and error flags. It sits between the serial pin and the `sr_9bit`/receive-buffer pair in the UART RX path.

---
 rtl/rcv_pkg.sv | 24 ++
 rtl/rcv_bit_timer.sv | 30 +++
 rtl/rcv_ctrl.sv | 161 ++++++++++++++++
 tb/tb_rcv_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rcv_pkg.sv
// Shared types and constants for the UART receive controller.
// Holds the FSM state encoding and the data-size clamp rule.
package rcv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    SAMPLE,
    CHECK,
    LOAD
  } rcv_state_t;

  localparam logic [3:0] RCV_MIN_DATA_SIZE = 4'd5;
  localparam logic [3:0] RCV_MAX_DATA_SIZE = 4'd8;

  // Out-of-range frame sizes fall back to the widest supported frame.
  function automatic logic [3:0] rcv_clamp_size(input logic [3:0] size);
    if ((size >= RCV_MIN_DATA_SIZE) && (size <= RCV_MAX_DATA_SIZE)) begin
      return size;
    end
    return RCV_MAX_DATA_SIZE;
  endfunction

endpackage

// File: rtl/rcv_bit_timer.sv
// Clear-able bit timer that counts 0..CLKS_PER_BIT-1 and wraps.
// wrap marks the last cycle of a bit period, i.e. the strobe point.
module rcv_bit_timer #(
  parameter int CLKS_PER_BIT = 10,
  parameter int TW           = $clog2(CLKS_PER_BIT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          enable,
  output logic [TW-1:0] count,
  output logic          wrap
);

  localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

  assign wrap = enable && (count == LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= wrap ? '0 : count + TW'(1);
    end
  end

endmodule

// File: rtl/rcv_ctrl.sv
// UART receive controller: synchronizes serial_in, sequences sr_9bit and flags frames.
// Optional start-bit glitch filter is compiled in with RCV_START_FILTER_EN.
module rcv_ctrl
  import rcv_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_in,
  input  logic [3:0] data_size,
  input  logic       stop_bit,
  input  logic       data_read,
  output logic       shift_strobe,
  output logic       sr_serial,
  output logic       load_buffer,
  output logic       data_ready,
  output logic       framing_error,
  output logic       overrun_error,
  output logic       rx_busy
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);

  rcv_state_t state, state_next;

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev_serial;
  logic                   start_det;
  logic                   timer_clear;
  logic                   timer_en;
  logic                   timer_wrap;
  logic [TW-1:0]          timer_count;
  logic [3:0]             size_q;
  logic [3:0]             bit_cnt;

  // Synchronizer idles high so reset never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync        <= '1;
      prev_serial <= 1'b1;
    end else begin
      sync        <= {sync[SYNC_STAGES-2:0], serial_in};
      prev_serial <= sync[SYNC_STAGES-1];
    end
  end

  assign sr_serial = sync[SYNC_STAGES-1];
  assign start_det = (state == IDLE) && prev_serial && !sr_serial;
  assign rx_busy   = (state != IDLE);

  rcv_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .TW          (TW)
  ) u_bit_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (timer_clear),
    .enable(timer_en),
    .count (timer_count),
    .wrap  (timer_wrap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next   = state;
    timer_clear  = 1'b0;
    timer_en     = 1'b0;
    shift_strobe = 1'b0;
    load_buffer  = 1'b0;
    case (state)
      IDLE: begin
        if (start_det) begin
          state_next  = START;
          timer_clear = 1'b1;
        end
      end
      START: begin
        timer_en = 1'b1;
        if (timer_count == HALF_LAST) begin
          timer_clear = 1'b1;
`ifdef RCV_START_FILTER_EN
          state_next  = sr_serial ? IDLE : SAMPLE;
`else
          state_next  = SAMPLE;
`endif
        end
      end
      SAMPLE: begin
        timer_en = 1'b1;
        if (timer_wrap) begin
          shift_strobe = 1'b1;
          // bit_cnt counts earlier strobes, so equality marks the stop-bit strobe.
          if (bit_cnt == size_q) begin
            state_next = CHECK;
          end
        end
      end
      CHECK: begin
        state_next = stop_bit ? LOAD : IDLE;
      end
      LOAD: begin
        load_buffer = 1'b1;
        state_next  = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      size_q        <= RCV_MAX_DATA_SIZE;
      bit_cnt       <= '0;
      framing_error <= 1'b0;
    end else begin
      if (start_det) begin
        size_q        <= rcv_clamp_size(data_size);
        bit_cnt       <= '0;
        framing_error <= 1'b0;
      end else begin
        if (shift_strobe) begin
          bit_cnt <= bit_cnt + 4'd1;
        end
        if ((state == CHECK) && !stop_bit) begin
          framing_error <= 1'b1;
        end
      end
    end
  end

  // A read in the same cycle as LOAD consumes the old frame, so no overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_ready    <= 1'b0;
      overrun_error <= 1'b0;
    end else if (load_buffer) begin
      data_ready <= 1'b1;
      if (data_ready && !data_read) begin
        overrun_error <= 1'b1;
      end else if (data_read) begin
        overrun_error <= 1'b0;
      end
    end else if (data_read && data_ready) begin
      data_ready    <= 1'b0;
      overrun_error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rcv_ctrl.sv
// Scoreboard bench for rcv_ctrl with a behavioural sr_9bit and frame-level reference model.
// Directed scenarios followed by randomized frames; a negedge monitor checks completions.
`timescale 1ns/1ps
module tb_rcv_ctrl;

  localparam int S    = 10;
  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       serial_in = 1'b1;
  logic [3:0] data_size = 4'd8;
  logic       data_read = 1'b0;
  logic       stop_bit;
  logic       shift_strobe, sr_serial, load_buffer, data_ready;
  logic       framing_error, overrun_error, rx_busy;
  logic [8:0] sr9;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [7:0] data;
    int         size;
    bit         stop;
  } frame_t;

  frame_t exp_q[$];

  bit   model_ready = 1'b0;
  bit   model_ovr   = 1'b0;
  bit   exp_ovr;
  bit   pend = 1'b0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   last_off = 0;
  int   nstrobe = 0;
  bit   prev_busy = 1'b0;
  bit   prev_fe = 1'b0;

  always #5 clk = ~clk;

  rcv_ctrl #(
    .CLKS_PER_BIT(S),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .serial_in    (serial_in),
    .data_size    (data_size),
    .stop_bit     (stop_bit),
    .data_read    (data_read),
    .shift_strobe (shift_strobe),
    .sr_serial    (sr_serial),
    .load_buffer  (load_buffer),
    .data_ready   (data_ready),
    .framing_error(framing_error),
    .overrun_error(overrun_error),
    .rx_busy      (rx_busy)
  );

  // Bench stand-in for sr_9bit: shifts right, newest bit enters at the top.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sr9 <= '1;
    else if (shift_strobe) sr9 <= {sr_serial, sr9[8:1]};
  end
  assign stop_bit = sr9[8];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, actual, expected, $time);
    end
  endtask

  function automatic int exp_size(input logic [3:0] v);
    return (v >= 5 && v <= 8) ? int'(v) : 8;
  endfunction

  // Monitor: frame timing, completions and flag predictions.
  always @(negedge clk) begin
    frame_t     f;
    logic [7:0] pd;
    cyc++;
    if (rst) begin
      prev_busy = 1'b0;
      prev_fe   = 1'b0;
      pend      = 1'b0;
      nstrobe   = 0;
    end else begin
      if (pend) begin
        check("ready_after_load", data_ready, 1);
        check("overrun_after_load", overrun_error, exp_ovr);
        pend = 1'b0;
      end
      if (rx_busy && !prev_busy) begin
        start_cyc = cyc;
        nstrobe   = 0;
        check("fe_clear_at_start", framing_error, 0);
      end
      if (shift_strobe) begin
        nstrobe++;
        check("strobe_offset", cyc - start_cyc, (nstrobe == 1) ? (S / 2 + S - 1) : (last_off + S));
        last_off = cyc - start_cyc;
      end
      if (load_buffer || (framing_error && !prev_fe)) begin
        if (exp_q.size() == 0) begin
          check("unexpected_completion", exp_q.size(), 1);
        end else begin
          f = exp_q.pop_front();
          check("frame_kind_load", load_buffer, f.stop);
          check("strobe_count", nstrobe, f.size + 1);
          if (load_buffer) begin
            pd = sr9[7:0] >> (8 - f.size);
            check("packet_data", pd, f.data);
            exp_ovr     = model_ready | model_ovr;
            model_ready = 1'b1;
            model_ovr   = exp_ovr;
            pend        = 1'b1;
          end
        end
      end
      prev_busy = rx_busy;
      prev_fe   = framing_error;
    end
  end

  task automatic send_frame(input logic [7:0] data, input logic [3:0] dsize, input bit stop, input int gap);
    frame_t f;
    int     n;
    n         = exp_size(dsize);
    f.data    = data & 8'((1 << n) - 1);
    f.size    = n;
    f.stop    = stop;
    data_size = dsize;
    exp_q.push_back(f);
    serial_in = 1'b0;
    repeat (S) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      serial_in = data[i];
      repeat (S) @(negedge clk);
    end
    serial_in = stop;
    repeat (S) @(negedge clk);
    serial_in = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic do_read();
    data_read = 1'b1;
    @(negedge clk);
    data_read = 1'b0;
    @(negedge clk);
    check("ready_after_read", data_ready, 0);
    check("overrun_after_read", overrun_error, 0);
    model_ready = 1'b0;
    model_ovr   = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_strobe"}, shift_strobe, 0);
    check({tag, "_load"}, load_buffer, 0);
    check({tag, "_ready"}, data_ready, 0);
    check({tag, "_fe"}, framing_error, 0);
    check({tag, "_ovr"}, overrun_error, 0);
    check({tag, "_busy"}, rx_busy, 0);
    check({tag, "_sr_serial"}, sr_serial, 1);
  endtask

  task automatic pulse_reset(input string tag);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs(tag);
    exp_q.delete();
    model_ready = 1'b0;
    model_ovr   = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int waited;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // 8-bit frame A5.
    send_frame(8'hA5, 4'd8, 1'b1, 6);
    do_read();

    // Framing error on a 5-bit frame.
    send_frame(8'h13, 4'd5, 1'b0, 6);
    check("fe_set", framing_error, 1);
    check("fe_no_ready", data_ready, 0);

    // Overrun: two frames without a read.
    send_frame(8'h3C, 4'd8, 1'b1, 5);
    send_frame(8'hC3, 4'd8, 1'b1, 5);
    check("overrun_set", overrun_error, 1);
    do_read();
    do_read();

    // Randomized frames, including out-of-range sizes and bad stop bits.
    for (int k = 0; k < 24; k++) begin
      send_frame(8'($urandom), 4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
                 int'($urandom_range(4, 12)));
      if ($urandom_range(0, 1) == 1) do_read();
    end

    // Break: line held low for well over a frame, must not retrigger.
    begin
      frame_t f;
      data_size = 4'd7;
      f.data = 8'h00;
      f.size = 7;
      f.stop = 1'b0;
      exp_q.push_back(f);
      serial_in = 1'b0;
      repeat (13 * S) @(negedge clk);
      check("break_fe", framing_error, 1);
      check("break_idle", rx_busy, 0);
      repeat (3 * S) @(negedge clk);
      check("break_no_retrigger", rx_busy, 0);
      serial_in = 1'b1;
      repeat (6) @(negedge clk);
    end

    // Reset while idle with a frame pending in the buffer.
    send_frame(8'h5A, 4'd6, 1'b1, 6);
    pulse_reset("idle_rst");

    // Reset after the 4th strobe of a frame.
    data_size = 4'd8;
    serial_in = 1'b0;
    repeat (S) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      serial_in = i[0];
      repeat (S) @(negedge clk);
    end
    check("strobes_before_reset", nstrobe, 4);
    serial_in = 1'b1;
    pulse_reset("frame_rst");
    send_frame(8'h96, 4'd8, 1'b1, 6);
    do_read();

`ifdef RCV_START_FILTER_EN
    // 3-cycle glitch: START is entered but abandoned without strobes.
    serial_in = 1'b0;
    repeat (3) @(negedge clk);
    serial_in = 1'b1;
    waited = 0;
    while (!rx_busy && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check("glitch_entered_start", rx_busy, 1);
    waited = 0;
    while (rx_busy && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("glitch_busy_within_6", (waited <= 6), 1);
    check("glitch_no_strobes", nstrobe, 0);
    repeat (2 * S) @(negedge clk);
    check("glitch_still_idle", rx_busy, 0);
`endif

    // Drain with a bounded wait.
    waited = 0;
    while (exp_q.size() != 0 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    check("queue_drained", exp_q.size(), 0);
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
